// File: rtl/hyperbus_pkg.sv
// Shared types and default timing limits for the HyperBus arbiter.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package hyperbus_pkg;

    // One-hot arbiter states
    typedef enum logic [3:0] {
        S_IDLE   = 4'b0001,
        S_ISSUE  = 4'b0010,
        S_ACTIVE = 4'b0100,
        S_ERROR  = 4'b1000
    } state_t;

    // Cycles allowed between command issue and the controller raising busy
    localparam int ISSUE_TIMEOUT_DEF = 8;
    // Cycles the controller may hold busy for one transaction
    localparam int TXN_TIMEOUT_DEF   = 1024;

endpackage

// File: rtl/hyperbus_rr_pick.sv
// Round-robin picker: first set request after last_owner, wrapping at NREQ.
// Latency: purely combinational.
// Backpressure: none; caller decides when the pick is consumed.
module hyperbus_rr_pick #(
    parameter int NREQ = 2,
    parameter int IDXW = 1
) (
    input  logic [NREQ-1:0] req,
    input  logic [IDXW-1:0] last_owner,
    output logic [NREQ-1:0] grant_oh,
    output logic [IDXW-1:0] grant_idx
);
    localparam int SW = IDXW + 1;

    logic          found;
    logic [SW-1:0] cand;

    // Scan candidates last_owner+1 .. last_owner+NREQ (mod NREQ), take the first requester
    always_comb begin
        grant_oh  = '0;
        grant_idx = '0;
        found     = 1'b0;
        cand      = '0;
        for (int k = 1; k <= NREQ; k++) begin
            cand = {1'b0, last_owner} + SW'(k);
            if (cand >= SW'(NREQ)) begin
                cand = cand - SW'(NREQ);
            end
            if (!found && req[cand[IDXW-1:0]]) begin
                found                     = 1'b1;
                grant_oh[cand[IDXW-1:0]]  = 1'b1;
                grant_idx                 = cand[IDXW-1:0];
            end
        end
    end

endmodule

// File: rtl/hyperbus_arbiter.sv
// Round-robin arbiter sharing one HyperBus controller among NREQ requesters.
// Latency: gnt one cycle after req is sampled in IDLE; rvalid/rdat one cycle after ctrl_dvalid.
// Backpressure: ctrl_busy holds off new issues; a stuck or failing controller parks the block in ERROR.
module hyperbus_arbiter
    import hyperbus_pkg::*;
#(
    parameter int NREQ          = 2,
    parameter int WIDTH         = 8,
    parameter int ISSUE_TIMEOUT = ISSUE_TIMEOUT_DEF,
    parameter int TXN_TIMEOUT   = TXN_TIMEOUT_DEF
) (
    input  logic                    clk,
    input  logic                    rstn,
    input  logic [NREQ-1:0]         req,
    input  logic [NREQ-1:0]         we,
    input  logic [NREQ-1:0]         reg_space,
    input  logic [32*NREQ-1:0]      adr,
    input  logic [2*WIDTH*NREQ-1:0] wdat,
    output logic [NREQ-1:0]         gnt,
    output logic [NREQ-1:0]         done,
    output logic [NREQ-1:0]         rvalid,
    output logic [2*WIDTH-1:0]      rdat,
    output logic [NREQ-1:0]         err,
    output logic [31:0]             ctrl_adr,
    output logic [2*WIDTH-1:0]      ctrl_dat,
    output logic                    ctrl_reg_space,
    output logic                    ctrl_rrq,
    output logic                    ctrl_wrq,
    input  logic                    ctrl_busy,
    input  logic                    ctrl_dvalid,
    input  logic [2*WIDTH-1:0]      ctrl_rdat,
    input  logic                    ctrl_error,
    output logic                    error_o
);
    localparam int IDXW = (NREQ > 1) ? $clog2(NREQ) : 1;
    localparam int DW   = 2 * WIDTH;
    localparam int CW   = $clog2(TXN_TIMEOUT + 1);

    state_t          state_q, state_d;
    logic            we_l_q, we_l_d;
    logic            rs_q, rs_d;
    logic [31:0]     adr_q, adr_d;
    logic [DW-1:0]   dat_q, dat_d;
    logic [DW-1:0]   rdat_q, rdat_d;
    logic [IDXW-1:0] owner_q, owner_d;
    logic [IDXW-1:0] last_q, last_d;
    logic [NREQ-1:0] gnt_q, gnt_d;
    logic [NREQ-1:0] done_q, done_d;
    logic [NREQ-1:0] rvalid_q, rvalid_d;
    logic [NREQ-1:0] err_q, err_d;
    logic [CW-1:0]   cnt_q, cnt_d;

    logic [NREQ-1:0] win_oh;
    logic [IDXW-1:0] win_idx;
    logic [NREQ-1:0] owner_oh;
    logic            win_we, win_rs;
    logic [31:0]     win_adr;
    logic [DW-1:0]   win_dat;

    hyperbus_rr_pick #(.NREQ(NREQ), .IDXW(IDXW)) u_pick (
        .req        (req),
        .last_owner (last_q),
        .grant_oh   (win_oh),
        .grant_idx  (win_idx)
    );

    // Mux the winning requester's command fields and decode the current owner
    always_comb begin
        win_we   = 1'b0;
        win_rs   = 1'b0;
        win_adr  = '0;
        win_dat  = '0;
        owner_oh = '0;
        for (int p = 0; p < NREQ; p++) begin
            if (win_idx == IDXW'(p)) begin
                win_we  = we[p];
                win_rs  = reg_space[p];
                win_adr = adr[p*32 +: 32];
                win_dat = wdat[p*DW +: DW];
            end
            owner_oh[p] = (owner_q == IDXW'(p));
        end
    end

    // Next-state logic; the timeout counter reloads on each state entry and only counts down to 1
    always_comb begin
        state_d  = state_q;
        we_l_d   = we_l_q;
        rs_d     = rs_q;
        adr_d    = adr_q;
        dat_d    = dat_q;
        owner_d  = owner_q;
        last_d   = last_q;
        cnt_d    = cnt_q;
        err_d    = err_q;
        gnt_d    = '0;
        done_d   = '0;
        rvalid_d = '0;
        rdat_d   = ctrl_dvalid ? ctrl_rdat : rdat_q;

        if (state_q == S_ACTIVE && !we_l_q && ctrl_dvalid) begin
            rvalid_d = owner_oh;
        end

        unique case (state_q)
            S_IDLE: begin
                if (|req && !ctrl_busy) begin
                    state_d = S_ISSUE;
                    we_l_d  = win_we;
                    rs_d    = win_rs;
                    adr_d   = win_adr;
                    dat_d   = win_dat;
                    owner_d = win_idx;
                    last_d  = win_idx;
                    gnt_d   = win_oh;
                    cnt_d   = CW'(ISSUE_TIMEOUT);
                end
            end
            S_ISSUE: begin
                if (ctrl_error) begin
                    state_d = S_ERROR;
                    err_d   = err_q | owner_oh;
                    cnt_d   = '0;
                end else if (ctrl_busy) begin
                    state_d = S_ACTIVE;
                    cnt_d   = CW'(TXN_TIMEOUT);
                end else if (cnt_q <= CW'(1)) begin
                    state_d = S_ERROR;
                    err_d   = err_q | owner_oh;
                    cnt_d   = '0;
                end else begin
                    cnt_d = cnt_q - CW'(1);
                end
            end
            S_ACTIVE: begin
                if (ctrl_error) begin
                    state_d = S_ERROR;
                    err_d   = err_q | owner_oh;
                    cnt_d   = '0;
                end else if (!ctrl_busy) begin
                    state_d = S_IDLE;
                    done_d  = owner_oh;
                    cnt_d   = '0;
                end else if (cnt_q <= CW'(1)) begin
                    state_d = S_ERROR;
                    err_d   = err_q | owner_oh;
                    cnt_d   = '0;
                end else begin
                    cnt_d = cnt_q - CW'(1);
                end
            end
            S_ERROR: begin
                state_d = S_ERROR;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    // State and command registers
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state_q  <= S_IDLE;
            we_l_q   <= 1'b0;
            rs_q     <= 1'b0;
            adr_q    <= '0;
            dat_q    <= '0;
            rdat_q   <= '0;
            owner_q  <= '0;
            last_q   <= IDXW'(NREQ - 1);
            gnt_q    <= '0;
            done_q   <= '0;
            rvalid_q <= '0;
            err_q    <= '0;
            cnt_q    <= '0;
        end else begin
            state_q  <= state_d;
            we_l_q   <= we_l_d;
            rs_q     <= rs_d;
            adr_q    <= adr_d;
            dat_q    <= dat_d;
            rdat_q   <= rdat_d;
            owner_q  <= owner_d;
            last_q   <= last_d;
            gnt_q    <= gnt_d;
            done_q   <= done_d;
            rvalid_q <= rvalid_d;
            err_q    <= err_d;
            cnt_q    <= cnt_d;
        end
    end

    // Requests are combinational so they fall in the same cycle as ctrl_busy, blocking a re-issue
    assign ctrl_rrq       = !we_l_q & ((state_q == S_ISSUE) | ((state_q == S_ACTIVE) & ctrl_busy));
    assign ctrl_wrq       =  we_l_q & ((state_q == S_ISSUE) | ((state_q == S_ACTIVE) & ctrl_busy));
    assign ctrl_adr       = adr_q;
    assign ctrl_dat       = dat_q;
    assign ctrl_reg_space = rs_q;
    assign gnt            = gnt_q;
    assign done           = done_q;
    assign rvalid         = rvalid_q;
    assign rdat           = rdat_q;
    assign err            = err_q;
    assign error_o        = (state_q == S_ERROR);

endmodule

// File: tb/tb_hyperbus_arbiter.sv
// Self-checking bench for hyperbus_arbiter with a transaction-level controller model.
// Latency: n/a.
// Backpressure: n/a.
module tb_hyperbus_arbiter;
    localparam int NREQ = 2;
    localparam int WIDTH = 8;
    localparam int DW = 2 * WIDTH;
    localparam int ITO = 8;
    localparam int TTO = 1024;

    logic                 clk = 1'b0;
    logic                 rstn;
    logic [NREQ-1:0]      req, we, reg_space;
    logic [32*NREQ-1:0]   adr;
    logic [DW*NREQ-1:0]   wdat;
    logic [NREQ-1:0]      gnt, done, rvalid, err;
    logic [DW-1:0]        rdat, ctrl_dat, ctrl_rdat;
    logic [31:0]          ctrl_adr;
    logic                 ctrl_reg_space, ctrl_rrq, ctrl_wrq;
    logic                 ctrl_busy, ctrl_dvalid, ctrl_error, error_o;

    int vectors = 0;
    int miscompares = 0;
    int exp_last;

    hyperbus_arbiter #(.NREQ(NREQ), .WIDTH(WIDTH), .ISSUE_TIMEOUT(ITO), .TXN_TIMEOUT(TTO)) dut (
        .clk(clk), .rstn(rstn), .req(req), .we(we), .reg_space(reg_space), .adr(adr), .wdat(wdat),
        .gnt(gnt), .done(done), .rvalid(rvalid), .rdat(rdat), .err(err),
        .ctrl_adr(ctrl_adr), .ctrl_dat(ctrl_dat), .ctrl_reg_space(ctrl_reg_space),
        .ctrl_rrq(ctrl_rrq), .ctrl_wrq(ctrl_wrq), .ctrl_busy(ctrl_busy),
        .ctrl_dvalid(ctrl_dvalid), .ctrl_rdat(ctrl_rdat), .ctrl_error(ctrl_error), .error_o(error_o)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] expv);
        vectors++;
        assert (obs === expv) else begin
            miscompares++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, expv);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Round-robin rule: first requester at (last+1), (last+2), ... mod NREQ
    function automatic int rr_winner(input logic [NREQ-1:0] r, input int last);
        logic [NREQ-1:0] t;
        for (int k = 1; k <= NREQ; k++) begin
            t = r >> ((last + k) % NREQ);
            if (t[0]) return (last + k) % NREQ;
        end
        return -1;
    endfunction

    task automatic do_reset();
        rstn = 1'b0;
        req = '0; we = '0; reg_space = '0; adr = '0; wdat = '0;
        ctrl_busy = 1'b0; ctrl_dvalid = 1'b0; ctrl_rdat = '0; ctrl_error = 1'b0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        rstn = 1'b1;
        tick();
        exp_last = NREQ - 1;
    endtask

    // One complete transaction: issue, idly cycles before busy, alen busy cycles, then done
    task automatic do_txn(input logic [NREQ-1:0] rq, input logic [NREQ-1:0] wv, input int idly,
                          input int alen, input logic [7:0] dvm, input logic drop,
                          input logic force_a, input logic [31:0] fa,
                          output logic [NREQ-1:0] g_obs, output int nwords);
        int w;
        logic [NREQ-1:0] oh, t;
        logic rd, rs, pend_v;
        logic [31:0] a;
        logic [DW-1:0] d, pend_d;
        req = rq; we = wv;
        for (int p = 0; p < NREQ; p++) begin
            adr[p*32 +: 32] = $urandom;
            wdat[p*DW +: DW] = DW'($urandom);
            reg_space[p] = 1'($urandom);
        end
        w = rr_winner(rq, exp_last);
        exp_last = w;
        if (force_a) adr[w*32 +: 32] = fa;
        oh = NREQ'(1) << w;
        a = adr[w*32 +: 32];
        d = wdat[w*DW +: DW];
        t = wv >> w; rd = !t[0];
        t = reg_space >> w; rs = t[0];
        nwords = 0;
        tick();
        g_obs = gnt;
        chk("gnt", 64'(gnt), 64'(oh));
        chk("done_idle", 64'(done), 64'(0));
        chk("ctrl_adr", 64'(ctrl_adr), 64'(a));
        chk("ctrl_dat", 64'(ctrl_dat), 64'(d));
        chk("ctrl_reg_space", 64'(ctrl_reg_space), 64'(rs));
        chk("issue_rq", 64'({ctrl_rrq, ctrl_wrq}), 64'({rd, !rd}));
        if (drop) req = '0;
        for (int i = 0; i < idly; i++) begin
            tick();
            chk("gnt_once", 64'(gnt), 64'(0));
            chk("issue_hold", 64'({ctrl_rrq, ctrl_wrq}), 64'({rd, !rd}));
        end
        ctrl_busy = 1'b1;
        pend_v = 1'b0;
        pend_d = '0;
        for (int i = 0; i < alen; i++) begin
            tick();
            chk("rvalid", 64'(rvalid), pend_v ? 64'(oh) : 64'(0));
            if (pend_v) chk("rdat", 64'(rdat), 64'(pend_d));
            if (rvalid != '0) nwords++;
            chk("active_rq", 64'({ctrl_rrq, ctrl_wrq}), 64'({rd, !rd}));
            chk("adr_stable", 64'(ctrl_adr), 64'(a));
            ctrl_dvalid = dvm[i];
            ctrl_rdat = DW'($urandom);
            pend_v = dvm[i] & rd;
            pend_d = ctrl_rdat;
        end
        ctrl_busy = 1'b0;
        #1;
        chk("rq_drop", 64'({ctrl_rrq, ctrl_wrq}), 64'(0));
        tick();
        ctrl_dvalid = 1'b0;
        chk("done", 64'(done), 64'(oh));
        chk("rvalid_last", 64'(rvalid), pend_v ? 64'(oh) : 64'(0));
        if (pend_v) chk("rdat_last", 64'(rdat), 64'(pend_d));
        if (rvalid != '0) nwords++;
        chk("no_error", 64'(error_o), 64'(0));
    endtask

    initial begin
        logic [NREQ-1:0] g;
        int nw, n;
        rstn = 1'b0;
        do_reset();
        chk("rst_gnt", 64'(gnt), 64'(0));
        chk("rst_done", 64'(done), 64'(0));
        chk("rst_rvalid", 64'(rvalid), 64'(0));
        chk("rst_err", 64'(err), 64'(0));
        chk("rst_rq", 64'({ctrl_rrq, ctrl_wrq}), 64'(0));
        chk("rst_error_o", 64'(error_o), 64'(0));
        chk("rst_rdat", 64'(rdat), 64'(0));
        chk("rst_ctrl_adr", 64'(ctrl_adr), 64'(0));
        chk("rst_ctrl_dat", 64'(ctrl_dat), 64'(0));

        // Both ports held requesting: owners alternate starting at 0
        for (int i = 0; i < 4; i++) begin
            do_txn(2'b11, NREQ'($urandom), 1, 2, 8'h00, 1'b0, 1'b0, 32'h0, g, nw);
            chk("rr_alternate", 64'(g), 64'(NREQ'(1) << (i % 2)));
        end

        // Randomized traffic against the model
        for (int i = 0; i < 40; i++) begin
            do_txn(NREQ'($urandom_range(1, 3)), NREQ'($urandom), $urandom_range(0, 4),
                   $urandom_range(1, 6), 8'($urandom), 1'($urandom), 1'b0, 32'h0, g, nw);
        end

        // Port 1 read at 0x104 returning two words
        do_txn(2'b10, 2'b00, 1, 3, 8'b0000_0101, 1'b0, 1'b1, 32'h0000_0104, g, nw);
        chk("p1_read_words", 64'(nw), 64'(2));

        // Busy held after reset blocks the grant until it falls
        do_reset();
        ctrl_busy = 1'b1;
        req = 2'b01;
        for (int i = 0; i < 5; i++) begin
            tick();
            chk("busy_block_gnt", 64'(gnt), 64'(0));
            chk("busy_block_rq", 64'({ctrl_rrq, ctrl_wrq}), 64'(0));
        end
        ctrl_busy = 1'b0;
        tick();
        chk("busy_release_gnt", 64'(gnt), 64'(1));

        // Issue timeout: busy never rises
        do_reset();
        req = 2'b01; we = 2'b00;
        tick();
        chk("to_gnt", 64'(gnt), 64'(1));
        n = 0;
        while (!error_o && n < 20) begin
            tick();
            n++;
        end
        chk("issue_timeout_cycles", 64'(n), 64'(ITO));
        chk("to_err", 64'(err), 64'(1));
        chk("to_rq", 64'({ctrl_rrq, ctrl_wrq}), 64'(0));
        req = 2'b11;
        for (int i = 0; i < 4; i++) begin
            tick();
            chk("err_ignore_gnt", 64'(gnt), 64'(0));
            chk("err_sticky", 64'(error_o), 64'(1));
        end

        // Controller error during ACTIVE
        do_reset();
        req = 2'b10; we = 2'b00;
        tick();
        chk("cerr_gnt", 64'(gnt), 64'(2));
        ctrl_busy = 1'b1;
        tick();
        ctrl_error = 1'b1;
        tick();
        ctrl_error = 1'b0;
        chk("cerr_error_o", 64'(error_o), 64'(1));
        chk("cerr_err", 64'(err), 64'(2));
        chk("cerr_no_done", 64'(done), 64'(0));
        ctrl_busy = 1'b0;
        tick();
        chk("cerr_no_done2", 64'(done), 64'(0));
        chk("cerr_rq", 64'({ctrl_rrq, ctrl_wrq}), 64'(0));

        // Transaction timeout: busy stuck high
        do_reset();
        req = 2'b01; we = 2'b01;
        tick();
        req = '0;
        ctrl_busy = 1'b1;
        tick();
        n = 0;
        while (!error_o && n < TTO + 50) begin
            tick();
            n++;
        end
        chk("txn_timeout_cycles", 64'(n), 64'(TTO));
        chk("txn_timeout_err", 64'(err), 64'(1));

        // Reset mid-transaction, then port 0 wins first again
        do_reset();
        req = 2'b11; we = 2'b00;
        tick();
        chk("rst_mid_gnt", 64'(gnt), 64'(1));
        ctrl_busy = 1'b1;
        tick();
        chk("rst_mid_active_rq", 64'(ctrl_rrq), 64'(1));
        rstn = 1'b0;
        #1;
        chk("rst_mid_rrq_drop", 64'(ctrl_rrq), 64'(0));
        tick();
        chk("rst_mid_no_done", 64'(done), 64'(0));
        ctrl_busy = 1'b0;
        @(negedge clk);
        rstn = 1'b1;
        tick();
        chk("rst_mid_first_gnt", 64'(gnt), 64'(1));
        chk("rst_mid_no_done2", 64'(done), 64'(0));

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/hyperbus_arbiter.md
HYPERBUS_ARBITER -- requirements
Module: hyperbus_arbiter

Interface
REQ-001 SHALL have parameter NREQ, default 2, number of requester ports (2..8).
REQ-002 SHALL have parameter WIDTH, default 8, HyperBus DQ width; each data word is 2*WIDTH bits.
REQ-003 SHALL have parameter ISSUE_TIMEOUT, default 8, the maximum clk cycles from command issue until ctrl_busy rises.
REQ-004 SHALL have parameter TXN_TIMEOUT, default 1024, the maximum clk cycles ctrl_busy may stay high per transaction.
REQ-005 SHALL have one clock and an asynchronous, active-low reset: clk, rstn.
REQ-006 Ports, as name  direction  width  meaning:
- clk  in  1  clock
- rstn  in  1  async active-low reset
- req  in  NREQ  per-requester transaction request, level
- we  in  NREQ  1 = write, 0 = read
- reg_space  in  NREQ  1 = register space
- adr  in  32*NREQ  per-requester address
- wdat  in  2*WIDTH*NREQ  per-requester write word
- gnt  out  NREQ  one-cycle command-accepted pulse
- done  out  NREQ  one-cycle completion pulse
- rvalid  out  NREQ  read word valid
- rdat  out  2*WIDTH  read data, shared by all requesters
- err  out  NREQ  sticky error, owner only
- ctrl_adr  out  32  address to the controller
- ctrl_dat  out  2*WIDTH  write word to the controller
- ctrl_reg_space  out  1  register-space select to the controller
- ctrl_rrq  out  1  read request to the controller
- ctrl_wrq  out  1  write request to the controller
- ctrl_busy  in  1  controller busy
- ctrl_dvalid  in  1  controller read data valid
- ctrl_rdat  in  2*WIDTH  controller read data
- ctrl_error  in  1  controller error
- error_o  out  1  arbiter in ERROR

Function
REQ-007 SHALL implement the states IDLE, ISSUE, ACTIVE and ERROR, one-hot encoded.
REQ-008 IDLE -> ISSUE SHALL occur only when |req is set and ctrl_busy == 0. In that cycle the block SHALL pick the round-robin winner, latch its we, reg_space, adr and wdat into the command registers, record the owner index, and pulse gnt[owner] on the following cycle.
REQ-009 Round-robin order SHALL start at (last_owner+1) mod NREQ and wrap at NREQ. After reset last_owner SHALL be NREQ-1, so that index 0 wins first.
REQ-010 ctrl_rrq SHALL equal !we_l & (ISSUE | (ACTIVE & ctrl_busy)), and ctrl_wrq SHALL equal the same expression with we_l in place of !we_l. These outputs are combinational so that they drop in the same cycle that ctrl_busy falls, which prevents a re-issue.
REQ-011 ctrl_adr, ctrl_dat and ctrl_reg_space SHALL come from the command registers and SHALL be stable from ISSUE until the return to IDLE.
REQ-012 ISSUE -> ACTIVE SHALL occur when ctrl_busy == 1. ISSUE -> ERROR SHALL occur after ISSUE_TIMEOUT cycles without ctrl_busy.
REQ-013 ACTIVE -> IDLE SHALL occur when ctrl_busy == 0, with done[owner] pulsed for one cycle. ACTIVE -> ERROR SHALL occur when TXN_TIMEOUT expires.
REQ-014 ctrl_error == 1 in ISSUE or ACTIVE SHALL move the block to ERROR (highest priority).
REQ-015 rvalid[owner] SHALL be a one-cycle-registered copy of ctrl_dvalid, asserted only in ACTIVE on read transactions; rdat SHALL be the registered ctrl_rdat.
REQ-016 ERROR SHALL be terminal until reset: error_o = 1, err[owner] = 1, gnt = 0, and all requests ignored.
REQ-017 The timeout counter SHALL be clog2(TXN_TIMEOUT+1) bits, reload on every state entry, and saturate, never wrapping.
REQ-018 If req drops while in ISSUE or ACTIVE, the transaction SHALL still complete; done SHALL still pulse.

Reset
REQ-019 On rstn low the block SHALL asynchronously enter IDLE, with gnt, done, rvalid, err, ctrl_rrq, ctrl_wrq and error_o at 0, rdat/ctrl_adr/ctrl_dat at 0, counter at 0, and last_owner at NREQ-1.
REQ-020 Reset mid-transaction SHALL drop ctrl_rrq and ctrl_wrq immediately and SHALL NOT pulse done.

Structure
REQ-021 The state encoding, ISSUE_TIMEOUT and TXN_TIMEOUT defaults SHALL reside in shared package hyperbus_pkg.
REQ-022 The round-robin priority picker SHALL be a combinational sub-module, hyperbus_rr_pick (inputs req, last_owner; outputs one-hot grant and index).

Verification
REQ-023 Scenario: req = 2'b11 held -> owners alternate 0,1,0,1, each gnt one cycle, with exactly one ctrl_rrq/ctrl_wrq transaction per grant.
REQ-024 Scenario: read from port 1 at adr 32'h0000_0104 with a controller model returning 2 dvalid words -> ctrl_adr = 0x104, ctrl_rrq = 1, rvalid[1] twice with the matching rdat, then done[1].
REQ-025 Scenario: ctrl_busy held high after reset while req[0] = 1 -> no gnt until busy falls, then gnt[0].
REQ-026 Scenario: ctrl_busy never rises after issue -> ERROR after 8 cycles, error_o = 1, err[owner] = 1, and later requests ignored.
REQ-027 Scenario: ctrl_error pulsed during ACTIVE -> ERROR next cycle, and done is not pulsed.
REQ-028 Scenario: rstn asserted in ACTIVE -> ctrl_rrq = 0 immediately, and port 0 wins first after release.
